axi4_frame_writer: RTL and testbench

//  Upstream stage of the DDR frame-buffer path. Accepts a 16-bit RGB565 pixel stream, packs four pixels per
//  64-bit word into an internal FIFO, and writes 64-beat INCR bursts into the back buffer of the DDR double buffer.
//  At end of frame it toggles buf_select; the display-side reader uses buf_select to pick its front buffer.

---
 rtl/axi4_frame_writer_if.sv | 40 ++++
 rtl/axi4_frame_writer.sv | 176 +++++++++++++++++
 tb/tb_axi4_frame_writer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_frame_writer_if.sv
// Pixel stream in, AXI4 write address/data/response out; "master" is the frame writer's view.
interface axi4_frame_writer_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
);
    logic                          pix_valid;
    logic                          pix_ready;
    logic [15:0]                   pix_data;
    logic                          pix_sof;

    logic [AXI_ADDR_WIDTH-1:0]     AWADDR;
    logic [7:0]                    AWLEN;
    logic [2:0]                    AWSIZE;
    logic [1:0]                    AWBURST;
    logic [3:0]                    AWCACHE;
    logic                          AWVALID;
    logic                          AWREADY;

    logic [AXI_DATA_WIDTH-1:0]     WDATA;
    logic [AXI_DATA_WIDTH/8-1:0]   WSTRB;
    logic                          WLAST;
    logic                          WVALID;
    logic                          WREADY;

    logic                          BVALID;
    logic                          BREADY;
    logic [1:0]                    BRESP;

    modport master (
        input  pix_valid, pix_data, pix_sof, AWREADY, WREADY, BVALID, BRESP,
        output pix_ready, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWVALID,
               WDATA, WSTRB, WLAST, WVALID, BREADY
    );

    modport slave (
        output pix_valid, pix_data, pix_sof, AWREADY, WREADY, BVALID, BRESP,
        input  pix_ready, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWVALID,
               WDATA, WSTRB, WLAST, WVALID, BREADY
    );
endinterface

// File: rtl/axi4_frame_writer.sv
// Packs RGB565 pixels 4-per-word into a FIFO and writes 64-beat INCR bursts into the DDR back buffer.
// Bursts start once 64 words are queued; pix_ready drops only when a 4th pixel would hit a full FIFO.
module axi4_frame_writer #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        FRAME_BYTES    = 153600,
    parameter int                        FIFO_DEPTH     = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BUF0_ADDR      = 32'h0100_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] BUF1_ADDR      = 32'h0110_0000
) (
    input  logic                clk_100Mhz,
    input  logic                rst,
    axi4_frame_writer_if.master bus,
    output logic                buf_select,
    output logic                frame_done,
    output logic                err_resp,
    output logic                err_sync
);
    localparam int                        FIFO_AW     = $clog2(FIFO_DEPTH);
    localparam int                        FRAME_PIX   = FRAME_BYTES / 2;
    localparam int                        POS_W       = $clog2(FRAME_PIX);
    localparam logic [POS_W-1:0]          LAST_POS    = POS_W'(FRAME_PIX - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(512);
    localparam logic [AXI_ADDR_WIDTH-1:0] FRAME_END   = AXI_ADDR_WIDTH'(FRAME_BYTES);
    localparam logic [FIFO_AW:0]          FIFO_FULL   = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]          BURST_WORDS = (FIFO_AW + 1)'(64);

    typedef enum logic [1:0] {IDLE, ADDR_SEND, DATA_WRITE, RESP_WAIT} state_t;

    state_t                      state;
    logic [1:0]                  pack_cnt;
    logic [47:0]                 pack_hi;
    logic [POS_W-1:0]            pos;
    logic                        synced;
    logic [AXI_DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]          wr_ptr;
    logic [FIFO_AW-1:0]          rd_ptr;
    logic [FIFO_AW:0]            fifo_cnt;
    logic                        fifo_full;
    logic                        pix_acc;
    logic                        store;
    logic                        push;
    logic                        pop;
    logic [5:0]                  beat;
    logic [AXI_ADDR_WIDTH-1:0]   offset;
    logic [AXI_ADDR_WIDTH-1:0]   next_offset;

    assign fifo_full     = (fifo_cnt == FIFO_FULL);
    assign bus.pix_ready = !rst && !(pack_cnt == 2'd3 && fifo_full);
    assign pix_acc       = bus.pix_valid && bus.pix_ready;
    // Pixels before the first SOF are accepted and dropped so upstream never stalls while unsynced.
    assign store         = pix_acc && (synced || bus.pix_sof);
    assign push          = store && (pack_cnt == 2'd3);
    assign pop           = bus.WVALID && bus.WREADY;
    assign next_offset   = offset + BURST_BYTES;

    assign bus.AWLEN   = 8'd63;
    assign bus.AWSIZE  = 3'b011;
    assign bus.AWBURST = 2'b01;
    assign bus.AWCACHE = 4'b1111;
    assign bus.WSTRB   = '1;
    assign bus.WDATA   = mem[rd_ptr];

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            pack_cnt <= 2'd0;
            pos      <= '0;
            synced   <= 1'b0;
            err_sync <= 1'b0;
        end else if (store) begin
            synced   <= 1'b1;
            if (bus.pix_sof && synced && pos != '0)
                err_sync <= 1'b1;
            pack_cnt <= pack_cnt + 2'd1;
            pos      <= (pos == LAST_POS) ? '0 : pos + 1'b1;
        end
    end

    // First pixel of a group lands in the MSBs, matching the reader's MSB-first unpacking.
    always_ff @(posedge clk_100Mhz) begin
        if (store) begin
            case (pack_cnt)
                2'd0:    pack_hi[47:32] <= bus.pix_data;
                2'd1:    pack_hi[31:16] <= bus.pix_data;
                2'd2:    pack_hi[15:0]  <= bus.pix_data;
                default: ;
            endcase
        end
        if (push)
            mem[wr_ptr] <= {pack_hi, bus.pix_data};
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state       <= IDLE;
            bus.AWADDR  <= '0;
            bus.AWVALID <= 1'b0;
            bus.WVALID  <= 1'b0;
            bus.WLAST   <= 1'b0;
            bus.BREADY  <= 1'b0;
            beat        <= 6'd0;
            offset      <= '0;
            buf_select  <= 1'b0;
            frame_done  <= 1'b0;
            err_resp    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A whole burst is already queued, so W never runs dry mid-burst.
                    if (fifo_cnt >= BURST_WORDS) begin
                        bus.AWADDR  <= (buf_select ? BUF1_ADDR : BUF0_ADDR) + offset;
                        bus.AWVALID <= 1'b1;
                        state       <= ADDR_SEND;
                    end
                end
                ADDR_SEND: begin
                    if (bus.AWREADY) begin
                        bus.AWVALID <= 1'b0;
                        bus.WVALID  <= 1'b1;
                        bus.WLAST   <= 1'b0;
                        beat        <= 6'd0;
                        state       <= DATA_WRITE;
                    end
                end
                DATA_WRITE: begin
                    if (bus.WREADY) begin
                        if (beat == 6'd63) begin
                            bus.WVALID <= 1'b0;
                            bus.WLAST  <= 1'b0;
                            bus.BREADY <= 1'b1;
                            state      <= RESP_WAIT;
                        end else begin
                            beat      <= beat + 6'd1;
                            bus.WLAST <= (beat == 6'd62);
                        end
                    end
                end
                RESP_WAIT: begin
                    if (bus.BVALID) begin
                        bus.BREADY <= 1'b0;
                        if (bus.BRESP != 2'b00)
                            err_resp <= 1'b1;
                        if (next_offset == FRAME_END) begin
                            offset     <= '0;
                            buf_select <= ~buf_select;
                            frame_done <= 1'b1;
                        end else begin
                            offset <= next_offset;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_frame_writer.sv
// Random-stimulus bench for axi4_frame_writer against a queue-based model of pixels, words and bursts.
module tb_axi4_frame_writer;
    localparam int          FB    = 3072;
    localparam int          FPIX  = FB / 2;
    localparam int          BPF   = FB / 512;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BUF0  = 32'h0100_0000;
    localparam logic [31:0] BUF1  = 32'h0110_0000;

    logic clk_100Mhz = 1'b0;
    logic rst;
    logic buf_select, frame_done, err_resp, err_sync;

    axi4_frame_writer_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) bus ();

    axi4_frame_writer #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .FRAME_BYTES(FB), .FIFO_DEPTH(DEPTH),
        .BUF0_ADDR(BUF0), .BUF1_ADDR(BUF1)
    ) dut (
        .clk_100Mhz(clk_100Mhz), .rst(rst), .bus(bus),
        .buf_select(buf_select), .frame_done(frame_done), .err_resp(err_resp), .err_sync(err_sync)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int          total = 0;
    int          bad = 0;
    logic [63:0] word_q[$];
    logic [63:0] cur;
    logic [63:0] w_exp;
    logic [63:0] w_prev;
    logic [63:0] first_wdata;
    logic [31:0] aw_prev;
    bit          first_seen = 0;
    int          npix, frames_m, fd_count, aw_idx, wb_done, b_done, beat, b_pend, stall_seen;
    bit          synced_m, err_sync_m, err_resp_m, fd_exp, aw_wait, w_wait;
    bit          stall_en, w_hold;
    int          err_burst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int i);
        logic [31:0] base;
        base = ((i / BPF) % 2 == 0) ? BUF0 : BUF1;
        return base + 32'(i % BPF) * 32'd512;
    endfunction

    task automatic model_reset();
        word_q.delete();
        cur = '0; npix = 0; synced_m = 0; err_sync_m = 0; err_resp_m = 0;
        frames_m = 0; fd_exp = 0; fd_count = 0; aw_idx = 0; wb_done = 0; b_done = 0;
        beat = 0; b_pend = 0; aw_wait = 0; w_wait = 0; stall_seen = 0;
    endtask

    // Slave side: ready/valid generation, one B response per completed burst.
    always @(posedge clk_100Mhz) begin
        #1;
        bus.AWREADY = stall_en ? 1'($urandom_range(1)) : 1'b1;
        bus.WREADY  = w_hold ? 1'b0 : (stall_en ? 1'($urandom_range(1)) : 1'b1);
        if (!rst && b_pend > 0 && (!stall_en || $urandom_range(1) == 1)) begin
            bus.BVALID = 1'b1;
            bus.BRESP  = (b_done == err_burst) ? 2'b10 : 2'b00;
        end else begin
            bus.BVALID = 1'b0;
            bus.BRESP  = 2'b00;
        end
    end

    // Monitor: handshakes seen here complete on the following rising edge.
    always @(negedge clk_100Mhz) begin
        if (!rst) begin
            chk("pix_ready", bus.pix_ready, !(synced_m && npix % 4 == 3 && word_q.size() == DEPTH));
            if (bus.pix_valid && !bus.pix_ready) stall_seen++;
            chk("frame_done", frame_done, fd_exp);
            if (frame_done) fd_count++;
            chk("buf_select", buf_select, frames_m % 2 == 1);
            chk("err_resp", err_resp, err_resp_m);
            chk("err_sync", err_sync, err_sync_m);
            fd_exp = 0;

            if (aw_wait) begin
                chk("awvalid_held", bus.AWVALID, 1);
                chk("awaddr_stable", bus.AWADDR, aw_prev);
            end
            if (bus.AWVALID && bus.AWREADY) begin
                chk("aw_single_outstanding", aw_idx, b_done);
                chk("awaddr", bus.AWADDR, exp_addr(aw_idx));
                chk("aw_attrs", {bus.AWLEN, bus.AWSIZE, bus.AWBURST, bus.AWCACHE}, {8'd63, 3'b011, 2'b01, 4'hF});
                aw_idx++;
            end
            aw_wait = bus.AWVALID && !bus.AWREADY;
            aw_prev = bus.AWADDR;

            if (w_wait) begin
                chk("wvalid_held", bus.WVALID, 1);
                chk("wdata_stable", bus.WDATA, w_prev);
            end
            if (bus.WVALID) begin
                chk("w_after_aw", aw_idx, wb_done + 1);
                chk("wlast", bus.WLAST, beat == 63);
                chk("wstrb", bus.WSTRB, 8'hFF);
            end else begin
                chk("wlast_idle", bus.WLAST, 0);
            end
            if (bus.WVALID && bus.WREADY) begin
                chk("fifo_model_nonempty", word_q.size() != 0, 1);
                if (word_q.size() != 0) begin
                    w_exp = word_q.pop_front();
                    chk("wdata", bus.WDATA, w_exp);
                end
                if (!first_seen) begin
                    first_wdata = bus.WDATA;
                    first_seen  = 1;
                end
                if (beat == 63) begin
                    beat = 0; wb_done++; b_pend++;
                end else begin
                    beat++;
                end
            end
            w_wait = bus.WVALID && !bus.WREADY;
            w_prev = bus.WDATA;

            if (bus.BVALID && bus.BREADY) begin
                chk("b_after_w", wb_done, b_done + 1);
                if (bus.BRESP != 2'b00) err_resp_m = 1;
                b_done++;
                b_pend--;
                if (b_done % BPF == 0) begin
                    fd_exp = 1;
                    frames_m++;
                end
            end
        end
    end

    task automatic send_pix(input logic [15:0] d, input logic sof, input int gap);
        bit acc;
        int t;
        if (gap > 0) begin
            bus.pix_valid = 1'b0;
            repeat (gap) begin @(posedge clk_100Mhz); #1; end
        end
        bus.pix_valid = 1'b1; bus.pix_data = d; bus.pix_sof = sof;
        acc = 0; t = 0;
        while (!acc && t < 3000) begin
            @(negedge clk_100Mhz);
            acc = bus.pix_ready;
            @(posedge clk_100Mhz); #1;
            t++;
        end
        if (!acc) chk("pix_accept_timeout", acc, 1);
        if (acc) begin
            if (sof && synced_m && npix % FPIX != 0) err_sync_m = 1;
            if (sof) synced_m = 1;
            if (synced_m) begin
                cur = {cur[47:0], d};
                npix++;
                if (npix % 4 == 0) word_q.push_back(cur);
            end
        end
        bus.pix_valid = 1'b0; bus.pix_sof = 1'b0;
    endtask

    task automatic wait_bursts(input int n);
        int t;
        t = 0;
        while (b_done < n && t < 6000) begin @(posedge clk_100Mhz); #1; t++; end
        chk("drain_bursts", b_done, n);
        repeat (3) begin @(posedge clk_100Mhz); #1; end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_awvalid"}, bus.AWVALID, 0);
        chk({tag, "_wvalid"}, bus.WVALID, 0);
        chk({tag, "_wlast"}, bus.WLAST, 0);
        chk({tag, "_bready"}, bus.BREADY, 0);
        chk({tag, "_pix_ready"}, bus.pix_ready, 0);
        chk({tag, "_buf_select"}, buf_select, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_err_resp"}, err_resp, 0);
        chk({tag, "_err_sync"}, err_sync, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        bus.pix_valid = 1'b0; bus.pix_data = '0; bus.pix_sof = 1'b0;
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = 2'b00;
        stall_en = 0; w_hold = 0; err_burst = BPF + 4;
        model_reset();
        repeat (3) @(posedge clk_100Mhz);
        @(negedge clk_100Mhz);
        check_reset_state("reset");
        @(posedge clk_100Mhz); #1;
        rst = 1'b0;

        // Unsynced pixels are swallowed.
        for (int i = 0; i < 5; i++) send_pix(16'($urandom), 1'b0, 0);

        // Frame 1: free-flowing slave, known first word.
        send_pix(16'h0001, 1'b1, 0);
        send_pix(16'h0002, 1'b0, 0);
        send_pix(16'h0003, 1'b0, 0);
        send_pix(16'h0004, 1'b0, 0);
        for (int i = 4; i < FPIX; i++) send_pix(16'($urandom), 1'b0, 0);
        wait_bursts(BPF);
        chk("first_wdata", first_wdata, 64'h0001_0002_0003_0004);
        chk("frame1_done_pulses", fd_count, 1);
        chk("frame1_buf_select", buf_select, 1);

        // Frame 2: random stalls on every channel, error response on its fifth burst.
        stall_en = 1;
        for (int i = 0; i < FPIX; i++) send_pix(16'($urandom), i == 0, int'($urandom_range(1)));
        wait_bursts(2 * BPF);
        stall_en = 0;
        chk("frame2_done_pulses", fd_count, 2);
        chk("frame2_buf_select", buf_select, 0);
        chk("frame2_err_resp", err_resp, 1);

        // Frame 3: W blocked long enough to fill the FIFO; stray SOF at pixel 100.
        w_hold = 1;
        fork
            begin
                repeat (1400) @(posedge clk_100Mhz);
                #1 w_hold = 0;
            end
        join_none
        for (int i = 0; i < FPIX; i++) send_pix(16'($urandom), i == 0 || i == 100, 0);
        wait_bursts(3 * BPF);
        chk("fifo_full_backpressure", stall_seen != 0, 1);
        chk("frame3_err_sync", err_sync, 1);
        chk("frame3_buf_select", buf_select, 1);
        chk("model_drained", word_q.size(), 0);

        // Frame 4: reset while a burst is in flight.
        for (int i = 0; i < 300; i++) send_pix(16'($urandom), i == 0, 0);
        t = 0;
        @(negedge clk_100Mhz);
        while (!bus.WVALID && t < 300) begin @(negedge clk_100Mhz); t++; end
        chk("burst_in_flight", bus.WVALID, 1);
        @(posedge clk_100Mhz); #1;
        rst = 1'b1;
        @(posedge clk_100Mhz);
        @(negedge clk_100Mhz);
        check_reset_state("midburst_reset");
        @(posedge clk_100Mhz); #1;
        model_reset();
        rst = 1'b0;
        repeat (5) @(posedge clk_100Mhz);
        @(negedge clk_100Mhz);
        chk("post_reset_pix_ready", bus.pix_ready, 1);
        chk("post_reset_awvalid", bus.AWVALID, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
